// File: rtl/uart_tx_arb.sv
// Two-requester round-robin arbiter feeding a single uart_tx byte interface.
// Grants one byte at a time, strobes it into the UART and waits for it to finish.
module uart_tx_arb #(
  parameter logic [7:0] START_TIMEOUT = 8'd255
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req0,
  input  logic [7:0] i_data0,
  output logic       o_gnt0,
  input  logic       i_req1,
  input  logic [7:0] i_data1,
  output logic       o_gnt1,
  output logic       o_tx_wr,
  output logic [7:0] o_tx_data,
  input  logic       i_tx_bsy,
  output logic       o_bsy,
  output logic       o_owner,
  output logic       o_timeout
);

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StIssue     = 2'd1,
    StWaitStart = 2'd2,
    StWaitDone  = 2'd3
  } state_e;

  state_e     state_q;
  logic [7:0] cnt_q;
  logic [7:0] cnt_inc;
  logic       any_req;
  logic       pick1;

  // With both requesters active the one that did not win last time goes next.
  always_comb begin
    any_req = i_req0 | i_req1;
    pick1   = i_req1 & (~i_req0 | ~o_owner);
    cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      cnt_q     <= 8'd0;
      o_gnt0    <= 1'b0;
      o_gnt1    <= 1'b0;
      o_tx_wr   <= 1'b0;
      o_timeout <= 1'b0;
      o_bsy     <= 1'b0;
      o_tx_data <= 8'h00;
      o_owner   <= 1'b1;
    end else begin
      o_gnt0    <= 1'b0;
      o_gnt1    <= 1'b0;
      o_tx_wr   <= 1'b0;
      o_timeout <= 1'b0;
      case (state_q)
        StIdle: begin
          if (!i_tx_bsy && any_req) begin
            state_q   <= StIssue;
            o_bsy     <= 1'b1;
            o_owner   <= pick1;
            o_tx_data <= pick1 ? i_data1 : i_data0;
            o_gnt0    <= ~pick1;
            o_gnt1    <= pick1;
          end
        end
        StIssue: begin
          state_q <= StWaitStart;
          o_tx_wr <= 1'b1;
          cnt_q   <= 8'd0;
        end
        StWaitStart: begin
          if (i_tx_bsy) begin
            state_q <= StWaitDone;
          end else if (cnt_inc == START_TIMEOUT) begin
            // UART never picked the byte up; give the bus back.
            state_q   <= StIdle;
            o_bsy     <= 1'b0;
            o_timeout <= 1'b1;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StWaitDone: begin
          if (!i_tx_bsy) begin
            state_q <= StIdle;
            o_bsy   <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          o_bsy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: directed vector table, then random traffic
// compared against a transfer-age reference model.
module tb_uart_tx_arb;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst, req0, req1, tx_bsy;
  logic [7:0] data0, data1;
  logic       gnt0, gnt1, tx_wr, bsy, owner, timeout;
  logic [7:0] tx_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_arb #(.START_TIMEOUT(8'(TO))) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_req0    (req0),
    .i_data0   (data0),
    .o_gnt0    (gnt0),
    .i_req1    (req1),
    .i_data1   (data1),
    .o_gnt1    (gnt1),
    .o_tx_wr   (tx_wr),
    .o_tx_data (tx_data),
    .i_tx_bsy  (tx_bsy),
    .o_bsy     (bsy),
    .o_owner   (owner),
    .o_timeout (timeout)
  );

  typedef struct {
    logic       rst, req0, req1, bsy_in;
    logic [7:0] d0, d1;
    logic       gnt0, gnt1, wr, to, bsy, owner;
    logic [7:0] data;
  } vec_t;

  vec_t vecs[23];

  // Reference model: tracks a transfer by its age in cycles since the grant.
  logic       m_active, m_started, m_owner, m_to;
  logic [7:0] m_data;
  int         m_age;

  task automatic model_step();
    logic w;
    if (rst) begin
      m_active = 0; m_started = 0; m_owner = 1; m_to = 0; m_data = 8'h00; m_age = 0;
    end else begin
      m_to = 0;
      if (!m_active) begin
        if (!tx_bsy && (req0 || req1)) begin
          w = (req0 && req1) ? ~m_owner : req1;
          m_owner = w; m_data = w ? data1 : data0;
          m_active = 1; m_started = 0; m_age = 0;
        end
      end else begin
        m_age++;
        if (m_age >= 2) begin
          if (!m_started) begin
            if (tx_bsy) m_started = 1;
            else if (m_age - 1 >= TO) begin
              m_active = 0; m_to = 1;
            end
          end else if (!tx_bsy) begin
            m_active = 0;
          end
        end
      end
    end
  endtask

  function automatic logic [13:0] actual();
    return {gnt0, gnt1, tx_wr, timeout, bsy, owner, tx_data};
  endfunction

  task automatic check(input string name, input logic [13:0] exp);
    checks++;
    if (actual() !== exp) begin
      errors++;
      $display("FAIL %s: got gnt0/gnt1/wr/to/bsy/owner/data=%b_%b_%b_%b_%b_%b_%h, expected %b_%b_%b_%b_%b_%b_%h",
               name, gnt0, gnt1, tx_wr, timeout, bsy, owner, tx_data,
               exp[13], exp[12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic q0, input logic q1, input logic bi,
                              input logic [7:0] a, input logic [7:0] b,
                              input logic g0, input logic g1, input logic w, input logic t,
                              input logic bo, input logic ow, input logic [7:0] d);
    vec_t v;
    v.rst = r; v.req0 = q0; v.req1 = q1; v.bsy_in = bi; v.d0 = a; v.d1 = b;
    v.gnt0 = g0; v.gnt1 = g1; v.wr = w; v.to = t; v.bsy = bo; v.owner = ow; v.data = d;
    return v;
  endfunction

  initial begin
    int thr;
    //               rst q0 q1 bsy d0     d1     g0 g1 wr to bo ow data
    vecs[0]  = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 8'h00); // reset
    vecs[1]  = mk(0, 1, 0, 0, 8'h55, 8'h00, 1, 0, 0, 0, 1, 0, 8'h55); // first grant to 0
    vecs[2]  = mk(0, 0, 0, 0, 8'h55, 8'h00, 0, 0, 1, 0, 1, 0, 8'h55); // write strobe
    vecs[3]  = mk(0, 0, 0, 0, 8'h55, 8'h00, 0, 0, 0, 0, 1, 0, 8'h55);
    vecs[4]  = mk(0, 0, 0, 1, 8'h55, 8'h00, 0, 0, 0, 0, 1, 0, 8'h55); // uart started
    vecs[5]  = mk(0, 0, 0, 1, 8'h55, 8'h00, 0, 0, 0, 0, 1, 0, 8'h55);
    vecs[6]  = mk(0, 0, 0, 0, 8'h55, 8'h00, 0, 0, 0, 0, 0, 0, 8'h55); // done
    vecs[7]  = mk(0, 1, 0, 1, 8'h12, 8'h00, 0, 0, 0, 0, 0, 0, 8'h55); // blocked by bsy
    vecs[8]  = mk(0, 1, 0, 1, 8'h12, 8'h00, 0, 0, 0, 0, 0, 0, 8'h55);
    vecs[9]  = mk(0, 1, 1, 0, 8'h12, 8'hC8, 0, 1, 0, 0, 1, 1, 8'hC8); // round-robin -> 1
    vecs[10] = mk(0, 1, 1, 0, 8'h12, 8'hC8, 0, 0, 1, 0, 1, 1, 8'hC8); // reqs ignored
    vecs[11] = mk(0, 1, 1, 0, 8'h12, 8'hC8, 0, 0, 0, 0, 1, 1, 8'hC8);
    vecs[12] = mk(0, 0, 0, 0, 8'h12, 8'hC8, 0, 0, 0, 0, 1, 1, 8'hC8);
    vecs[13] = mk(0, 0, 0, 0, 8'h12, 8'hC8, 0, 0, 0, 0, 1, 1, 8'hC8);
    vecs[14] = mk(0, 0, 0, 0, 8'h12, 8'hC8, 0, 0, 0, 1, 0, 1, 8'hC8); // timeout
    vecs[15] = mk(0, 1, 1, 0, 8'hAA, 8'hC8, 1, 0, 0, 0, 1, 0, 8'hAA); // grant after timeout
    vecs[16] = mk(0, 0, 0, 0, 8'hAA, 8'hC8, 0, 0, 1, 0, 1, 0, 8'hAA);
    vecs[17] = mk(0, 0, 0, 1, 8'hAA, 8'hC8, 0, 0, 0, 0, 1, 0, 8'hAA);
    vecs[18] = mk(1, 0, 0, 1, 8'hAA, 8'hC8, 0, 0, 0, 0, 0, 1, 8'h00); // reset in WAIT_DONE
    vecs[19] = mk(0, 1, 1, 0, 8'hAA, 8'hC8, 1, 0, 0, 0, 1, 0, 8'hAA); // req0 wins after reset
    vecs[20] = mk(1, 0, 0, 0, 8'hAA, 8'hC8, 0, 0, 0, 0, 0, 1, 8'h00); // reset in ISSUE, no wr
    vecs[21] = mk(0, 0, 1, 0, 8'hAA, 8'h33, 0, 1, 0, 0, 1, 1, 8'h33); // lone req1 wins
    vecs[22] = mk(0, 0, 0, 0, 8'hAA, 8'h33, 0, 0, 1, 0, 1, 1, 8'h33);

    rst = 1; req0 = 0; req1 = 0; tx_bsy = 0; data0 = 0; data1 = 0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      rst = vecs[i].rst; req0 = vecs[i].req0; req1 = vecs[i].req1;
      tx_bsy = vecs[i].bsy_in; data0 = vecs[i].d0; data1 = vecs[i].d1;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), {vecs[i].gnt0, vecs[i].gnt1, vecs[i].wr, vecs[i].to,
                                     vecs[i].bsy, vecs[i].owner, vecs[i].data});
    end

    // Random traffic; first cycle forces reset so the model starts in step.
    thr = 50;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (c % 250 == 0) thr = (c / 250) % 3 == 0 ? 20 : ((c / 250) % 3 == 1 ? 50 : 85);
      rst    = (c == 0) || ($urandom_range(0, 199) == 0);
      req0   = $urandom_range(0, 99) < 60;
      req1   = $urandom_range(0, 99) < 60;
      data0  = 8'($urandom);
      data1  = 8'($urandom);
      tx_bsy = $urandom_range(0, 99) < thr;
      model_step();
      @(posedge clk); #1;
      check("random", {m_active && m_age == 0 && !m_owner, m_active && m_age == 0 && m_owner,
                       m_active && m_age == 1, m_to, m_active, m_owner, m_data});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter START_TIMEOUT, default 8'd255, meaning max i_clk cycles to wait for i_tx_bsy after a write strobe; legal range 1..255.
REQ-002 SHALL have port i_clk  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port i_req0  input  1  requester 0 has a byte to send.
REQ-005 SHALL have port i_data0  input  8  requester 0 byte.
REQ-006 SHALL have port o_gnt0  output  1  one-cycle pulse: requester 0 byte accepted.
REQ-007 SHALL have ports i_req1, i_data1[7:0], o_gnt1, identical in meaning for requester 1.
REQ-008 SHALL have port o_tx_wr  output  1  write strobe to uart_tx i_wr.
REQ-009 SHALL have port o_tx_data  output  8  byte to uart_tx i_data.
REQ-010 SHALL have port i_tx_bsy  input  1  uart_tx o_bsy.
REQ-011 SHALL have port o_bsy  output  1  arbiter not idle.
REQ-012 SHALL have port o_owner  output  1  index of the requester granted most recently.
REQ-013 SHALL have port o_timeout  output  1  one-cycle pulse: uart_tx failed to start.

Function
REQ-014 SHALL implement states IDLE, ISSUE, WAIT_START, WAIT_DONE; all outputs registered.
REQ-015 In IDLE with i_tx_bsy=0 and at least one request, SHALL move to ISSUE, latch the winner's data into o_tx_data, set o_owner to the winner, pulse its o_gnt for one cycle.
REQ-016 In IDLE with i_tx_bsy=1, SHALL not grant and SHALL stay in IDLE.
REQ-017 Arbitration SHALL be round-robin: with both requests, the requester != o_owner wins; with one request, that requester wins regardless of o_owner.
REQ-018 ISSUE SHALL last exactly one cycle with o_tx_wr=1, then move to WAIT_START and clear the timeout counter.
REQ-019 Latency: request sampled at edge k -> o_gnt high in cycle after edge k, o_tx_wr high in cycle after edge k+1, low after edge k+2.
REQ-020 WAIT_START SHALL move to WAIT_DONE when i_tx_bsy=1; counter SHALL increment each cycle, 8-bit, saturating at 255.
REQ-021 WAIT_START SHALL, when counter reaches START_TIMEOUT with i_tx_bsy still 0, pulse o_timeout for one cycle and return to IDLE; o_owner unchanged.
REQ-022 WAIT_DONE SHALL return to IDLE on the first cycle i_tx_bsy=0.
REQ-023 o_tx_data SHALL stay stable from the grant cycle until the next grant.
REQ-024 o_bsy SHALL be 1 in every state except IDLE.
REQ-025 A request dropped before its grant SHALL be treated as withdrawn, with no grant and no transfer.
REQ-026 A request still held in the cycle after o_gnt SHALL be treated as a new request for the next byte.
REQ-027 o_gnt0 and o_gnt1 SHALL never be high in the same cycle; at most one grant per IDLE->ISSUE transition.
REQ-028 Requests arriving in any state other than IDLE SHALL be ignored until IDLE; no queuing.

Reset
REQ-029 On the edge where i_rst=1, state SHALL become IDLE; counter 0; o_gnt0, o_gnt1, o_tx_wr, o_timeout, o_bsy 0; o_tx_data 8'h00; o_owner 1, so requester 0 wins first.
REQ-030 Reset asserted mid-transfer (ISSUE, WAIT_START or WAIT_DONE) SHALL abort with no further o_tx_wr; no grant in any cycle with i_rst=1.
REQ-031 After i_rst falls, first grant SHALL be possible at the next edge with a request and i_tx_bsy=0.

Verification
REQ-032 Reset, then i_req0=1, i_data0=8'h55, uart_tx attached -> o_gnt0 one pulse, o_tx_wr one pulse, o_tx_data=8'h55, serial 0x55 received, o_bsy=0 after i_tx_bsy falls.
REQ-033 Both requests held, i_data0=8'hAA, i_data1=8'hC8 -> bytes sent AA, C8, AA, C8; grants alternate; o_owner toggles.
REQ-034 Only i_req1 held for 3 bytes -> three consecutive o_gnt1, no o_gnt0.
REQ-035 i_tx_bsy tied 0, START_TIMEOUT=4 -> o_timeout pulses 4 cycles after the WAIT_START entry; return to IDLE; next grant follows.
REQ-036 i_rst pulsed during WAIT_DONE -> outputs at REQ-029 values next edge; next simultaneous request goes to requester 0.
REQ-037 i_req0 raised while i_tx_bsy=1 in IDLE -> no grant until i_tx_bsy=0, then grant in the following cycle.
